// File: rtl/siso_shift_register_if.sv
// Bundle of the shift register's data-path signals.
// There is no valid/ready handshake on this block: en qualifies Din on each
// rising clk edge, while Dout and primed are plain registered status outputs.
interface siso_shift_register_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] Din;
    logic [WIDTH-1:0] Dout;
    logic             primed;

    // Master drives the stream into the register and observes its outputs.
    modport master (
        output en,
        output Din,
        input  Dout,
        input  primed
    );

    // Slave is the shift register itself.
    modport slave (
        input  en,
        input  Din,
        output Dout,
        output primed
    );
endinterface

// File: rtl/siso_shift_register.sv
// Serial-in serial-out shift register / delay line.
// Din reappears on Dout after DEPTH enabled edges. primed goes high on the
// edge where the first post-reset sample lands on Dout and stays high until rst.
module siso_shift_register #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    siso_shift_register_if.slave  bus
);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [CW-1:0]    fill;
    logic             primed_q;

    // Shift chain, saturating fill counter and primed flag; rst beats en.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
            fill     <= '0;
            primed_q <= 1'b0;
        end else if (bus.en) begin
            stage[0] <= bus.Din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
            if (fill != FULL) begin
                fill <= fill + 1'b1;
            end
            // Counter reaches DEPTH on this edge, or already has.
            if (fill >= LAST) begin
                primed_q <= 1'b1;
            end
        end
    end

    assign bus.Dout   = stage[DEPTH-1];
    assign bus.primed = primed_q;
endmodule

// File: tb/tb_siso_shift_register.sv
// Directed and random checks of siso_shift_register: a DEPTH=4 WIDTH=1 main
// instance and a DEPTH=1 WIDTH=8 corner instance sharing clk and rst.
module tb_siso_shift_register;
    localparam int DEPTH = 4;
    localparam int WIDTH = 1;

    logic clk;
    logic rst;

    siso_shift_register_if #(.WIDTH(WIDTH)) bus ();
    siso_shift_register_if #(.WIDTH(8))     bus2 ();

    siso_shift_register #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    siso_shift_register #(.DEPTH(1), .WIDTH(8)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_q[$];

    // one rising edge with the given inputs, then sample 1 time unit later
    task automatic step(input logic r, input logic e, input logic d);
        rst     = r;
        bus.en  = e;
        bus.Din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic seq    [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp_d  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_p  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    int   cnt;
    logic e;
    logic d;

    initial begin
        rst      = 1'b1;
        bus.en   = 1'b1;
        bus.Din  = 1'b1;
        bus2.en  = 1'b1;
        bus2.Din = 8'h00;

        // reset: two edges with Din=1, en=1
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1);
            chk("reset_dout",   32'(bus.Dout),   32'd0);
            chk("reset_primed", 32'(bus.primed), 32'd0);
        end

        // basic delay
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, seq[i]);
            chk($sformatf("basic_dout_%0d", i + 1),   32'(bus.Dout),   32'(exp_d[i]));
            chk($sformatf("basic_primed_%0d", i + 1), 32'(bus.primed), 32'(exp_p[i]));
        end

        // enable hold: push 1,0 ; hold 3 ; push 1,1 ; flush with 0s
        step(1'b1, 1'b1, 1'b0);
        chk("hold_reset_primed", 32'(bus.primed), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("hold1_dout", 32'(bus.Dout), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("hold3_primed", 32'(bus.primed), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        chk("hold_push3_dout",   32'(bus.Dout),   32'd0);
        chk("hold_push3_primed", 32'(bus.primed), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        chk("hold_push4_dout",   32'(bus.Dout),   32'd1);
        chk("hold_push4_primed", 32'(bus.primed), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("hold_push5_dout", 32'(bus.Dout), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("hold_push6_dout", 32'(bus.Dout), 32'd1);
        // second hold while a 1 sits on Dout and a 1 is next
        step(1'b0, 1'b0, 1'b0);
        chk("hold2a_dout", 32'(bus.Dout), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("hold2b_dout", 32'(bus.Dout), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("hold_push7_dout", 32'(bus.Dout), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("hold_push8_dout", 32'(bus.Dout), 32'd0);

        // reset mid-stream: push 1,1,1, reset, then 0s
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("mid_reset_dout",   32'(bus.Dout),   32'd0);
        chk("mid_reset_primed", 32'(bus.primed), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("mid_dout_%0d", i + 1),   32'(bus.Dout),   32'd0);
            chk($sformatf("mid_primed_%0d", i + 1), 32'(bus.primed), (i == 3) ? 32'd1 : 32'd0);
        end

        // DEPTH=1 WIDTH=8 corner
        step(1'b1, 1'b1, 1'b0);
        chk("d1_reset_dout",   32'(bus2.Dout),   32'h00);
        chk("d1_reset_primed", 32'(bus2.primed), 32'd0);
        bus2.Din = 8'hA5;
        step(1'b0, 1'b1, 1'b0);
        chk("d1_dout_a5", 32'(bus2.Dout),   32'hA5);
        chk("d1_primed",  32'(bus2.primed), 32'd1);
        bus2.Din = 8'h3C;
        step(1'b0, 1'b1, 1'b0);
        chk("d1_dout_3c", 32'(bus2.Dout), 32'h3C);

        // random stream with random enable against a reference queue
        step(1'b1, 1'b1, 1'b0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('0);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            e = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            step(1'b0, e, d);
            if (e) begin
                void'(exp_q.pop_front());
                exp_q.push_back(d);
                if (cnt < DEPTH) cnt++;
            end
            chk($sformatf("rand_dout_%0d", i),   32'(bus.Dout),   32'(exp_q[0]));
            chk($sformatf("rand_primed_%0d", i), 32'(bus.primed), (cnt >= DEPTH) ? 32'd1 : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
